slot_config_seq: RTL and testbench

- Sequencer that programs the slotmaker configuration port (slot, wr, card_i, reconfig) with a card-to-slot map, replacing the tied-off config inputs.
- Runs once after reset, after a debounced change of the "alternate map" DIP switch, and on software request.
- Sits between the apple_bus DIP outputs / control logic and slotmaker_config_if, in the clk_logic domain.

---
 rtl/slot_config_seq_if.sv | 22 ++
 rtl/slot_config_seq.sv | 181 ++++++++++++++++++
 tb/tb_slot_config_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/slot_config_seq_if.sv
// Slotmaker configuration port: the sequencer drives it through the master
// modport and the slotmaker receives it through the slave modport.
interface slot_config_seq_if;
  logic [2:0] cfg_slot_o;
  logic       cfg_wr_o;
  logic [7:0] cfg_card_o;
  logic       cfg_reconfig_o;

  modport master (
    output cfg_slot_o,
    output cfg_wr_o,
    output cfg_card_o,
    output cfg_reconfig_o
  );

  modport slave (
    input cfg_slot_o,
    input cfg_wr_o,
    input cfg_card_o,
    input cfg_reconfig_o
  );
endinterface

// File: rtl/slot_config_seq.sv
// Programs the slotmaker card-to-slot map after reset, after a debounced change
// of the alternate-map switch, and on request; all outputs are registered.
module slot_config_seq #(
  parameter logic [63:0] SLOT_MAP_PRI    = 64'h01000002_00000300,
  parameter logic [63:0] SLOT_MAP_ALT    = 64'h02000000_01000300,
  parameter int unsigned DEBOUNCE_CYCLES = 54_000,
  parameter int unsigned RECONFIG_HOLD   = 16
) (
  input  logic                      clk_logic,
  input  logic                      device_reset_n,
  input  logic                      alt_map_i,
  input  logic                      req_i,
  slot_config_seq_if.master         cfg,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      map_sel_o
);

  localparam int unsigned DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = (RECONFIG_HOLD > 1) ? $clog2(RECONFIG_HOLD) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RECONFIG_HOLD - 1);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_WRITE,
    ST_COMMIT,
    ST_HOLD,
    ST_IDLE
  } state_t;

  // ---------------------------------------------------------------------------
  // Switch debounce: runs in every state, emits a one-cycle change event.
  // ---------------------------------------------------------------------------
  logic [DEB_W-1:0] deb_cnt;
  logic             alt_stable;
  logic             differ;
  logic             chg;

  assign differ = (alt_map_i != alt_stable);
  assign chg    = differ && (deb_cnt == DEB_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk_logic) begin
    if (!device_reset_n) begin
      deb_cnt    <= '0;
      alt_stable <= 1'b0;
    end else if (!differ) begin
      deb_cnt    <= '0;
    end else if (chg) begin
      alt_stable <= alt_map_i;
      deb_cnt    <= '0;
    end else begin
      deb_cnt    <= deb_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer. Each edge performs the action of the current state and
  // registers its outputs, so outputs trail the state register by one cycle.
  // ---------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [63:0]       map_q, map_d;
  logic              pending_q, pending_d;
  logic [2:0]        slot_q, slot_d;
  logic [7:0]        card_q, card_d;
  logic              wr_q, wr_d;
  logic              reconfig_q, reconfig_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sel_q, sel_d;
  logic              trigger;

  assign trigger = req_i || chg;

  // NOTE: every variable gets a default before the case statement, so no path
  // leaves one unassigned and no latch can be inferred.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hold_d     = hold_q;
    map_d      = map_q;
    pending_d  = pending_q || trigger;
    slot_d     = slot_q;
    card_d     = card_q;
    wr_d       = 1'b0;
    reconfig_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = done_q;
    sel_d      = sel_q;

    unique case (state_q)
      ST_LOAD: begin
        busy_d    = 1'b1;
        map_d     = alt_stable ? SLOT_MAP_ALT : SLOT_MAP_PRI;
        sel_d     = alt_stable;
        pending_d = trigger;  // a request arriving in LOAD still earns a rerun
        idx_d     = 3'd0;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        busy_d = 1'b1;
        wr_d   = 1'b1;
        slot_d = idx_q;
        card_d = map_q[{idx_q, 3'b000} +: 8];  // byte n is the card for slot n
        idx_d  = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        busy_d     = 1'b1;
        reconfig_d = 1'b1;
        hold_d     = '0;
        state_d    = ST_HOLD;
      end
      ST_HOLD: begin
        busy_d = 1'b1;
        if (hold_q == HOLD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_IDLE: begin
        done_d = 1'b1;
        if (pending_q || trigger) begin
          pending_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // NOTE: the map snapshot and slot/card holding registers are reset along with
  // the control state so the outputs are fully defined straight out of reset.
  always_ff @(posedge clk_logic) begin
    if (!device_reset_n) begin
      state_q    <= ST_LOAD;
      idx_q      <= '0;
      hold_q     <= '0;
      map_q      <= '0;
      pending_q  <= 1'b0;
      slot_q     <= '0;
      card_q     <= '0;
      wr_q       <= 1'b0;
      reconfig_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      hold_q     <= hold_d;
      map_q      <= map_d;
      pending_q  <= pending_d;
      slot_q     <= slot_d;
      card_q     <= card_d;
      wr_q       <= wr_d;
      reconfig_q <= reconfig_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sel_q      <= sel_d;
    end
  end

  assign cfg.cfg_slot_o     = slot_q;
  assign cfg.cfg_wr_o       = wr_q;
  assign cfg.cfg_card_o     = card_q;
  assign cfg.cfg_reconfig_o = reconfig_q;
  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign map_sel_o          = sel_q;

endmodule

// File: tb/tb_slot_config_seq.sv
// Self-checking bench for slot_config_seq: directed scenarios plus random
// stimulus, compared cycle by cycle against a sequence-position model.
module tb_slot_config_seq;

  localparam int unsigned D = 4;
  localparam int unsigned H = 2;
  localparam logic [63:0] PRI = 64'h01000002_00000300;
  localparam logic [63:0] ALT = 64'h02000000_01000300;
  localparam int IDLE_POS = 10 + H;  // LOAD, 8 writes, commit, H holds

  logic clk_logic = 1'b0;
  logic device_reset_n = 1'b0;
  logic alt_map_i = 1'b0;
  logic req_i = 1'b0;
  logic busy_o, done_o, map_sel_o;

  slot_config_seq_if cfg();

  slot_config_seq #(
    .SLOT_MAP_PRI    (PRI),
    .SLOT_MAP_ALT    (ALT),
    .DEBOUNCE_CYCLES (D),
    .RECONFIG_HOLD   (H)
  ) dut (
    .clk_logic      (clk_logic),
    .device_reset_n (device_reset_n),
    .alt_map_i      (alt_map_i),
    .req_i          (req_i),
    .cfg            (cfg),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .map_sel_o      (map_sel_o)
  );

  always #5 clk_logic = ~clk_logic;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: position within a sequence (0 = LOAD ... IDLE_POS = idle)
  // and a run-length view of the switch debounce.
  int          m_pos;
  int          m_run;
  logic        m_stable, m_pending;
  logic [63:0] m_map;
  logic        m_busy, m_done, m_sel, m_wr, m_rec;
  logic [2:0]  m_slot;
  logic [7:0]  m_card;

  task automatic model_edge(input logic r, input logic a, input logic q);
    logic old_stable;
    logic ev;
    if (!r) begin
      m_pos = 0; m_run = 0; m_stable = 0; m_pending = 0; m_map = '0;
      m_busy = 0; m_done = 0; m_sel = 0; m_wr = 0; m_rec = 0; m_slot = 0; m_card = 0;
      return;
    end
    old_stable = m_stable;
    ev = 1'b0;
    if (a != m_stable) begin
      m_run++;
      if (m_run == int'(D)) begin
        ev = 1'b1; m_stable = a; m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_wr = 0; m_rec = 0; m_busy = 1;
    if (m_pos == 0) begin
      m_map = old_stable ? ALT : PRI;
      m_sel = old_stable;
      m_pending = q | ev;
      m_pos = 1;
    end else if (m_pos <= 8) begin
      m_wr = 1;
      m_slot = 3'(m_pos - 1);
      m_card = m_map[8*(m_pos-1) +: 8];
      m_pending = m_pending | q | ev;
      m_pos++;
    end else if (m_pos < IDLE_POS) begin
      m_rec = (m_pos == 9);
      m_pending = m_pending | q | ev;
      m_pos++;
    end else begin
      m_busy = 0;
      m_done = 1;
      if (m_pending | q | ev) begin
        m_pos = 0; m_pending = 0;
      end
    end
  endtask

  int   cyc;        // cycles since the last reset cycle
  int   seq_starts; // busy_o rising edges seen
  logic prev_busy = 1'b0;

  task automatic cycle(input logic r, input logic a, input logic q, input string tag);
    device_reset_n = r;
    alt_map_i      = a;
    req_i          = q;
    @(posedge clk_logic);
    model_edge(r, a, q);
    @(negedge clk_logic);
    cyc = r ? cyc + 1 : 0;
    if (busy_o && !prev_busy) seq_starts++;
    prev_busy = busy_o;
    check(tag,
          {16'b0, busy_o, done_o, map_sel_o, cfg.cfg_wr_o, cfg.cfg_reconfig_o,
           cfg.cfg_slot_o, cfg.cfg_card_o},
          {16'b0, m_busy, m_done, m_sel, m_wr, m_rec, m_slot, m_card});
  endtask

  task automatic do_reset(input logic a);
    cycle(1'b0, a, 1'b0, "reset");
    cycle(1'b0, a, 1'b0, "reset");
  endtask

  initial begin
    int first_wr;
    int busy_fall;
    logic a;

    // Primary map after reset; first write and busy fall at fixed cycles.
    do_reset(1'b0);
    check("reset_busy", {31'b0, busy_o}, 32'd0);
    check("reset_wr", {31'b0, cfg.cfg_wr_o}, 32'd0);
    first_wr = 0; busy_fall = 0;
    for (int i = 1; i <= 16; i++) begin
      cycle(1'b1, 1'b0, 1'b0, "pri_seq");
      if (cfg.cfg_wr_o && first_wr == 0) first_wr = cyc;
      if (!busy_o && busy_fall == 0) busy_fall = cyc;
    end
    check("first_wr_cycle", first_wr, 32'd2);
    check("busy_fall_cycle", busy_fall, 32'(IDLE_POS + 1));
    check("done_after_seq", {31'b0, done_o}, 32'd1);

    // Switch held high from reset: exactly one extra sequence, alternate map.
    do_reset(1'b1);
    seq_starts = 0;
    for (int i = 1; i <= 40; i++) cycle(1'b1, 1'b1, 1'b0, "alt_seq");
    check("alt_seq_count", seq_starts, 32'd2);
    check("alt_map_sel", {31'b0, map_sel_o}, 32'd1);

    // Three-cycle glitch while idle is ignored.
    do_reset(1'b0);
    for (int i = 1; i <= 16; i++) cycle(1'b1, 1'b0, 1'b0, "glitch_pre");
    seq_starts = 0;
    for (int i = 1; i <= 30; i++) cycle(1'b1, (i <= 3), 1'b0, "glitch");
    check("glitch_seq_count", seq_starts, 32'd0);

    // Requests during WRITE and HOLD merge into one rerun.
    do_reset(1'b0);
    seq_starts = 0;
    for (int i = 1; i <= 45; i++) cycle(1'b1, 1'b0, (i == 5 || i == 12), "req_merge");
    check("req_merge_count", seq_starts, 32'd2);

    // Reset pulse in the middle of the write burst.
    do_reset(1'b0);
    for (int i = 1; i <= 7; i++) cycle(1'b1, 1'b0, 1'b0, "mid_pre");
    cycle(1'b0, 1'b0, 1'b0, "mid_reset");
    check("mid_reset_done", {31'b0, done_o}, 32'd0);
    seq_starts = 0;
    for (int i = 1; i <= 20; i++) cycle(1'b1, 1'b0, 1'b0, "mid_post");
    check("mid_post_count", seq_starts, 32'd1);

    // Request coinciding with a debounced change while idle.
    do_reset(1'b0);
    for (int i = 1; i <= 20; i++) cycle(1'b1, 1'b0, 1'b0, "sim_pre");
    seq_starts = 0;
    for (int i = 1; i <= 40; i++) cycle(1'b1, 1'b1, (i == int'(D)), "simul");
    check("simul_count", seq_starts, 32'd1);
    check("simul_map_sel", {31'b0, map_sel_o}, 32'd1);

    // Random stimulus: sticky switch with occasional glitches, sparse requests
    // and rare resets.
    a = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      cycle(($urandom_range(0, 299) != 0), a, ($urandom_range(0, 19) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
